// File: rtl/coherence_bus_pkg.sv
// Shared types for the L1/L2 coherence bus sequencer.
package coherence_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    SRC_PEER = 2'b01,
    SRC_L2   = 2'b10,
    SRC_NONE = 2'b11
  } resp_src_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_L2_WAIT,
    ST_RESP
  } seq_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_select
  import coherence_bus_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          valid
);

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && req[(32'(ptr) + k) % N]) begin
        valid      = 1'b1;
        winner_idx = IW'((32'(ptr) + k) % N);
        winner[(32'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transaction_sequencer.sv
// Round-robin coherence bus sequencer: grant, snoop, optional L2 access, one-cycle response.
module bus_transaction_sequencer
  import coherence_bus_pkg::*;
#(
  parameter int unsigned N_CORES    = 2,
  parameter int unsigned L2_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    req,
  input  logic [2*N_CORES-1:0]  op,
  input  logic [32*N_CORES-1:0] addr,
  output logic [N_CORES-1:0]    grant,
  output logic [N_CORES-1:0]    done,
  output logic [1:0]            resp_src,
  output logic [31:0]           resp_data,
  output logic                  snoop_valid,
  output logic [1:0]            snoop_op,
  output logic [31:0]           snoop_addr,
  input  logic [N_CORES-1:0]    snoop_hit,
  input  logic [32*N_CORES-1:0] snoop_data,
  output logic                  l2_req,
  output logic [31:0]           l2_addr,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  input  logic [31:0]           l2_data,
  output logic                  l2_timeout_err,
  output logic                  busy
);

  localparam int unsigned IW = idx_width(N_CORES);
  localparam int unsigned CW = $clog2(L2_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(L2_TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d;
  bus_op_t          op_q, op_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d;
  resp_src_t        src_q, src_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_CORES-1:0] sel_onehot;
  logic [IW-1:0]      sel_idx;
  logic               sel_valid;
  logic [1:0]         sel_op;
  logic [31:0]        sel_addr;
  logic               peer_hit;
  logic [31:0]        peer_data;

  rr_priority_select #(.N(N_CORES), .IW(IW)) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (sel_onehot),
    .winner_idx (sel_idx),
    .valid      (sel_valid)
  );

  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (sel_onehot[i]) begin
        sel_op   = sel_op   | op[2*i +: 2];
        sel_addr = sel_addr | addr[32*i +: 32];
      end
    end
  end

  // Lowest-index hitting peer supplies data; the owner's own hit bit is masked.
  always_comb begin
    peer_hit  = 1'b0;
    peer_data = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (!peer_hit && snoop_hit[i] && (owner_q != IW'(i))) begin
        peer_hit  = 1'b1;
        peer_data = snoop_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    src_d   = src_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_idx;
          op_d    = bus_op_t'(sel_op);
          addr_d  = sel_addr;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (op_q == BUS_NON || op_q == BUS_UPGR) begin
          src_d   = SRC_NONE;
          data_d  = '0;
          state_d = ST_RESP;
        end else if (peer_hit) begin
          src_d   = SRC_PEER;
          data_d  = peer_data;
          state_d = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_L2_WAIT;
        end
      end
      ST_L2_WAIT: begin
        // A response landing on the final wait cycle beats the timeout.
        if (l2_ready) begin
          src_d   = l2_hit ? SRC_L2 : SRC_NONE;
          data_d  = l2_hit ? l2_data : '0;
          state_d = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          src_d   = SRC_NONE;
          data_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (owner_q == IW'(N_CORES - 1)) ? '0 : owner_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      op_q    <= BUS_NON;
      addr_q  <= '0;
      src_q   <= SRC_NONE;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      grant[i] = (state_q != ST_IDLE) && (owner_q == IW'(i));
      done[i]  = (state_q == ST_RESP) && (owner_q == IW'(i));
    end
  end

  assign resp_src       = (state_q == ST_RESP) ? src_q : SRC_NONE;
  assign resp_data      = (state_q == ST_RESP) ? data_q : '0;
  assign snoop_valid    = (state_q == ST_SNOOP) && (op_q != BUS_NON);
  assign snoop_op       = op_q;
  assign snoop_addr     = addr_q;
  assign l2_req         = (state_q == ST_L2_WAIT);
  assign l2_addr        = addr_q;
  assign l2_timeout_err = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/bus_transaction_sequencer.md
# bus_transaction_sequencer

Sequential arbiter and transaction sequencer for the shared coherence bus between `N_CORES` L1 data caches and the unified L2. It grants the bus to one requester at a time in round-robin order. Each granted transaction runs as snoop phase, then optional L2 access, then a one-cycle response. It sits between the per-core cache controllers and the L2 port, and replaces a purely combinational toggle grant with a latched, multi-cycle handshake.

## Interface
Parameters:
- `N_CORES`, 2, number of requesting L1 controllers (2..8)
- `L2_TIMEOUT`, 15, max cycles waiting for `l2_ready` before abort

Ports (flat vectors; core i occupies slice i):
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; clock and reset are as decided: one clock, synchronous active-high reset
- `req`  in  N_CORES  bus request per core, level
- `op`  in  2*N_CORES  bus op per core: BusRd 2'b00, BusUpgr 2'b01, BusRdX 2'b10, BusNoN 2'b11
- `addr`  in  32*N_CORES  transaction address per core
- `grant`  out  N_CORES  one-hot (or zero) bus ownership
- `done`  out  N_CORES  one-cycle completion pulse to owner
- `resp_src`  out  2  2'b01 peer L1, 2'b10 L2, 2'b11 none
- `resp_data`  out  32  response data, valid while any `done` bit is high
- `snoop_valid`  out  1  snoop broadcast strobe
- `snoop_op`  out  2  latched op during snoop
- `snoop_addr`  out  32  latched address during snoop
- `snoop_hit`  in  N_CORES  per-core snoop hit, sampled in SNOOP
- `snoop_data`  in  32*N_CORES  per-core snoop data
- `l2_req`  out  1  L2 access request, level
- `l2_addr`  out  32  L2 address
- `l2_ready`  in  1  L2 response valid
- `l2_hit`  in  1  L2 hit qualifier, valid with `l2_ready`
- `l2_data`  in  32  L2 read data
- `l2_timeout_err`  out  1  sticky error, cleared only by reset
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, SNOOP, L2_WAIT, RESP.
- IDLE: if any `req`, select the first set bit at or after `rr_ptr` (wrapping). Latch owner index, its `op` and `addr`. Then go to SNOOP. Otherwise stay in IDLE.
- `grant[owner]` = 1 in SNOOP, L2_WAIT and RESP. `grant` = 0 in IDLE.
- SNOOP (exactly 1 cycle), `snoop_valid` = 1, with one exception: for BusNoN, `snoop_valid` stays 0 and the FSM goes to RESP with src 2'b11.
- SNOOP, BusUpgr: go to RESP, src 2'b11, data 0. This is invalidate only, with no L2 access.
- SNOOP, BusRd/BusRdX with a non-owner `snoop_hit`: take data from the lowest-index hitting non-owner. Go to RESP with src 2'b01.
- The owner's own `snoop_hit` bit is ignored.
- SNOOP, BusRd/BusRdX with no hit: go to L2_WAIT.
- L2_WAIT: `l2_req` = 1, `l2_addr` = latched address.
- On `l2_ready`: if `l2_hit`, src 2'b10 with `l2_data`; else src 2'b11 with data 0. Then go to RESP.
- Timeout counter resets on entry to L2_WAIT. If it reaches `L2_TIMEOUT` without `l2_ready`, set `l2_timeout_err`, use src 2'b11 with data 0, and go to RESP.
- RESP (1 cycle): `done[owner]` = 1, and `resp_src`/`resp_data` come from registers. Then `rr_ptr` ← (owner+1) mod `N_CORES`, and the FSM goes to IDLE.
- Outside RESP: `resp_src` = 2'b11, `resp_data` = 0.
- Deasserting `req` after it has been latched does not abort the transaction; it runs to `done`.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `done` 0, `resp_src` 2'b11, `resp_data` 0, `snoop_valid` 0, `snoop_op` 2'b11, `snoop_addr` 0, `l2_req` 0, `l2_addr` 0, `l2_timeout_err` 0, `busy` 0.
- Reset during any state returns to IDLE on the next edge. No `done` is issued for the aborted transaction.
- Latency is counted with `req` sampled in IDLE at cycle 0:
  - grant and snoop at cycle 1
  - peer-hit, BusUpgr or BusNoN: `done` at cycle 2
  - L2 path: `l2_req` from cycle 2; `l2_ready` at cycle k gives `done` at k+1
- Back-to-back: IDLE occupies one cycle between transactions. The minimum issue interval is 3 cycles.
- When all `N_CORES` request continuously, each core is granted once per `N_CORES` transactions.
- `l2_ready` arriving in the same cycle the counter hits `L2_TIMEOUT`: `l2_ready` wins and no error is set.
- `l2_ready` outside L2_WAIT is ignored.

## Structure
- Package `coherence_bus_pkg` holds:
  - `bus_op_t` enum (BUS_RD, BUS_UPGR, BUS_RDX, BUS_NON)
  - `resp_src_t` enum (SRC_PEER=01, SRC_L2=10, SRC_NONE=11)
  - `seq_state_t`
- Sub-module `rr_priority_select`: combinational. Inputs are request vector and pointer; outputs are one-hot winner, winner index and valid.
- Timeout counter width = $clog2(L2_TIMEOUT+1).

## Test plan
- `req`=2'b11 held, all ops BusRd, `snoop_hit` 0, `l2_ready` 1 cycle after `l2_req`, `l2_hit` 1, `l2_data`=0xCAFE0000+i → grants alternate core0, core1, core0; each `done` has src 2'b10 and matching data; no cycle with two grant bits set.
- Core1 BusRd addr 0x100; core0 `snoop_hit`=1, data 0xDEADBEEF → `done[1]` at cycle 2, src 2'b01, data 0xDEADBEEF; `l2_req` never asserted.
- Core0 BusUpgr addr 0x40 → `snoop_valid` at cycle 1 with `snoop_op` 2'b01; `done[0]` at cycle 2, src 2'b11; no `l2_req`.
- Core0 BusRdX, no hit, `l2_ready` withheld → `done[0]` at cycle 2+`L2_TIMEOUT`, src 2'b11, `l2_timeout_err`=1 until reset.
- Reset asserted in L2_WAIT → next cycle all outputs at reset values; following `req[1]` is granted first (`rr_ptr`=0 scan, core0 idle).
- Core0 drops `req` in SNOOP → transaction completes and `done[0]` still pulses.
